// File: rtl/load_counter_seq_ctrl.sv
// Sweep sequencer driving a loadable up/down counter through repeated start->end runs.
// Optional macro LOAD_CNT_SEQ_PINGPONG_EN: reverse direction between sweeps instead of reloading.
module load_counter_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_end,
    input  logic             cmd_dir,
    input  logic [REP_W-1:0] cmd_reps,
    input  logic             abort,
    output logic             cnt_load,
    output logic             cnt_mode,
    output logic [WIDTH-1:0] cnt_in,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [REP_W-1:0] sweep_idx
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   start_r;
    logic [WIDTH-1:0]   end_r;
    logic               dir_r;
    logic [REP_W-1:0]   reps_left;
    logic [WIDTH-1:0]   hold_r;

    logic accept;
    logic rep_hit;
    logic final_hit;
    logic abort_hit;
    logic hit;

    assign hit = (cnt_q == end_r);

    // Outside a sweep the counter is kept frozen by reloading the value it already holds.
    always_comb begin
        next_state = state;
        cnt_load   = 1'b1;
        cnt_in     = hold_r;
        cnt_mode   = 1'b0;
        cmd_ready  = 1'b0;
        accept     = 1'b0;
        rep_hit    = 1'b0;
        final_hit  = 1'b0;
        abort_hit  = 1'b0;
        if (rst) begin
            cnt_in = '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        accept     = 1'b1;
                        cnt_in     = cmd_start;
                        next_state = RUN;
                    end
                end
                RUN: begin
                    cnt_mode = dir_r;
                    if (abort) begin
                        abort_hit  = 1'b1;
                        cnt_in     = cnt_q;
                        next_state = IDLE;
                    end else if (hit) begin
                        if (reps_left != '0) begin
                            rep_hit = 1'b1;
`ifdef LOAD_CNT_SEQ_PINGPONG_EN
                            cnt_load = 1'b0;
                            cnt_mode = !dir_r;
`else
                            cnt_in = start_r;
`endif
                        end else begin
                            final_hit  = 1'b1;
                            cnt_in     = end_r;
                            next_state = IDLE;
                        end
                    end else begin
                        cnt_load = 1'b0;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            start_r   <= '0;
            end_r     <= '0;
            dir_r     <= 1'b0;
            reps_left <= '0;
            hold_r    <= '0;
            sweep_idx <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state   <= next_state;
            busy    <= (next_state == RUN);
            done    <= final_hit;
            aborted <= abort_hit;
            if (accept) begin
                start_r   <= cmd_start;
                end_r     <= cmd_end;
                dir_r     <= cmd_dir;
                reps_left <= cmd_reps;
                sweep_idx <= '0;
            end
            if (rep_hit) begin
                reps_left <= reps_left - REP_W'(1);
                sweep_idx <= sweep_idx + REP_W'(1);
`ifdef LOAD_CNT_SEQ_PINGPONG_EN
                start_r <= end_r;
                end_r   <= start_r;
                dir_r   <= !dir_r;
`endif
            end
            if (final_hit) begin
                hold_r <= end_r;
            end
            if (abort_hit) begin
                hold_r <= cnt_q;
            end
        end
    end

endmodule

// File: tb/tb_load_counter_seq_ctrl.sv
// Directed bench for load_counter_seq_ctrl with a behavioural model of the loadable counter.
module tb_load_counter_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_start;
    logic [3:0] cmd_end;
    logic       cmd_dir;
    logic [3:0] cmd_reps;
    logic       abort;
    logic       cnt_load;
    logic       cnt_mode;
    logic [3:0] cnt_in;
    logic [3:0] cnt_q;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [3:0] sweep_idx;

    int checks   = 0;
    int failures = 0;

    logic [3:0] trace_q[$];
    logic [3:0] idx_q[$];
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    load_counter_seq_ctrl #(.WIDTH(4), .REP_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_end   (cmd_end),
        .cmd_dir   (cmd_dir),
        .cmd_reps  (cmd_reps),
        .abort     (abort),
        .cnt_load  (cnt_load),
        .cnt_mode  (cnt_mode),
        .cnt_in    (cnt_in),
        .cnt_q     (cnt_q),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .sweep_idx (sweep_idx)
    );

    // The counter being sequenced: shares rst, loads on load, otherwise steps every cycle.
    always @(posedge clk) begin
        if (rst)           cnt_q <= 4'd0;
        else if (cnt_load) cnt_q <= cnt_in;
        else if (cnt_mode) cnt_q <= cnt_q - 4'd1;
        else               cnt_q <= cnt_q + 4'd1;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] s, input logic [3:0] e, input logic d, input logic [3:0] r);
        cmd_start = s;
        cmd_end   = e;
        cmd_dir   = d;
        cmd_reps  = r;
        cmd_valid = 1'b1;
        #1;
        check("accept_ready", cmd_ready, 1);
        check("accept_load", cnt_load, 1);
        check("accept_in", cnt_in, s);
        step();
        cmd_valid = 1'b0;
    endtask

    // Records cnt_q and sweep_idx for every busy cycle, bounded.
    task automatic capture(input int limit);
        int n = 0;
        trace_q.delete();
        idx_q.delete();
        while (busy && n < limit) begin
            trace_q.push_back(cnt_q);
            idx_q.push_back(sweep_idx);
            step();
            n++;
        end
        check("capture_terminates", busy, 0);
    endtask

    task automatic check_trace(input string tag);
        check({tag, "_len"}, trace_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < trace_q.size(); i++) begin
            check($sformatf("%s_q%0d", tag, i), trace_q[i], exp_q[i]);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_start = 4'd0;
        cmd_end   = 4'd0;
        cmd_dir   = 1'b0;
        cmd_reps  = 4'd0;
        abort     = 1'b0;

        step();
        step();
        check("rst_load", cnt_load, 1);
        check("rst_in", cnt_in, 0);
        check("rst_mode", cnt_mode, 0);
        check("rst_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_idx", sweep_idx, 0);
        check("rst_q", cnt_q, 0);
        rst = 1'b0;
        #1;
        check("idle_ready", cmd_ready, 1);
        check("idle_load", cnt_load, 1);

        // Plain up sweep, then hold for ten cycles.
        issue(4'd2, 4'd5, 1'b0, 4'd0);
        check("t1_busy", busy, 1);
        check("t1_ready_run", cmd_ready, 0);
        check("t1_mode", cnt_mode, 0);
        capture(40);
        exp_q = '{4'd2, 4'd3, 4'd4, 4'd5};
        check_trace("t1");
        check("t1_done", done, 1);
        check("t1_hold", cnt_q, 5);
        step();
        check("t1_done_pulse", done, 0);
        for (int i = 0; i < 10; i++) step();
        check("t1_hold_10", cnt_q, 5);

        // Up sweep across the wrap point; next command offered in the done cycle.
        issue(4'd14, 4'd1, 1'b0, 4'd0);
        capture(40);
        exp_q = '{4'd14, 4'd15, 4'd0, 4'd1};
        check_trace("t2");
        check("t2_done", done, 1);
        check("t2_hold", cnt_q, 1);

        // Abort mid-sweep, accepted back-to-back with the done cycle above.
        issue(4'd0, 4'd9, 1'b0, 4'd0);
        check("t4_done_cleared", done, 0);
        for (int n = 0; n < 20 && cnt_q != 4'd4; n++) step();
        check("t4_reach4", cnt_q, 4);
        abort = 1'b1;
        #1;
        check("t4_abort_load", cnt_load, 1);
        check("t4_abort_in", cnt_in, 4);
        step();
        abort = 1'b0;
        check("t4_busy", busy, 0);
        check("t4_aborted", aborted, 1);
        check("t4_no_done", done, 0);
        check("t4_hold", cnt_q, 4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_aborted_pulse", aborted, 0);
        check("t4_idle_abort_ignored", cnt_q, 4);
        check("t4_idle_busy", busy, 0);
        issue(4'd7, 4'd8, 1'b0, 4'd0);
        capture(40);
        exp_q = '{4'd7, 4'd8};
        check_trace("t4_next");
        check("t4_next_done", done, 1);

`ifndef LOAD_CNT_SEQ_PINGPONG_EN
        // Zero-distance sweeps repeated three times.
        step();
        issue(4'd3, 4'd3, 1'b1, 4'd2);
        check("t3_mode", cnt_mode, 1);
        capture(40);
        exp_q = '{4'd3, 4'd3, 4'd3};
        check_trace("t3");
        check("t3_idx0", idx_q.size() > 0 ? idx_q[0] : 4'hx, 0);
        check("t3_idx1", idx_q.size() > 1 ? idx_q[1] : 4'hx, 1);
        check("t3_idx2", idx_q.size() > 2 ? idx_q[2] : 4'hx, 2);
        check("t3_done", done, 1);
        check("t3_hold", cnt_q, 3);
`else
        // Ping-pong: second sweep runs back down without reloading.
        step();
        issue(4'd1, 4'd3, 1'b0, 4'd1);
        capture(40);
        exp_q = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1};
        check_trace("t6");
        check("t6_done", done, 1);
        check("t6_hold", cnt_q, 1);
        step();
        check("t6_hold_after", cnt_q, 1);
`endif

        // Reset in the middle of a sweep.
        step();
        issue(4'd0, 4'd9, 1'b0, 4'd0);
        for (int n = 0; n < 20 && cnt_q != 4'd6; n++) step();
        check("t5_reach6", cnt_q, 6);
        rst = 1'b1;
        #1;
        check("t5_rst_load", cnt_load, 1);
        check("t5_rst_in", cnt_in, 0);
        check("t5_rst_ready", cmd_ready, 0);
        step();
        rst = 1'b0;
        #1;
        check("t5_q", cnt_q, 0);
        check("t5_busy", busy, 0);
        check("t5_ready", cmd_ready, 1);
        check("t5_done", done, 0);
        check("t5_aborted", aborted, 0);
        step();
        check("t5_done_after", done, 0);
        check("t5_aborted_after", aborted, 0);
        check("t5_q_hold", cnt_q, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
